// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and helpers for the Ibex data-memory responder.
package ibex_mem_resp_pkg;

  localparam int unsigned RESP_INTG_W = 7;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_entry_t;

  // span is 33 bits so a window ending at 2**32 still compares correctly
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    return (addr >= base) && ({1'b0, addr - base} < span);
  endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth response delay line with synchronous clear.
module ibex_mem_resp_pipe
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  resp_entry_t push,
  output resp_entry_t head
);

  resp_entry_t stage [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < Depth; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[Depth-1];

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted SECDED(39,32) encoder: data passes through, check bits in [38:32].
module prim_secded_inv_39_32_enc (
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  always_comb begin
    data_o     = {7'd0, data_i};
    data_o[32] = ^(data_o & 39'h002606BD25);
    data_o[33] = ^(data_o & 39'h00DEBA8050);
    data_o[34] = ^(data_o & 39'h00413D89AA);
    data_o[35] = ^(data_o & 39'h0031234ED1);
    data_o[36] = ^(data_o & 39'h00C2C1323B);
    data_o[37] = ^(data_o & 39'h002DCC624C);
    data_o[38] = ^(data_o & 39'h0098505586);
    data_o     = data_o ^ 39'h2A00000000;
  end

endmodule

// File: rtl/ibex_data_mem_responder.sv
// Far-end responder for the Ibex data bus: word array, fixed-latency responses.
// Define IBEX_RESP_INTG_CHECK_EN to reject writes whose integrity bits are wrong.
module ibex_data_mem_responder
  import ibex_mem_resp_pkg::*;
#(
  parameter int unsigned MemWords        = 1024,
  parameter logic [31:0] BaseAddr        = 32'h0000_0000,
  parameter int unsigned ResponseLatency = 1,
  parameter int unsigned MaxOutstanding  = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   data_req_i,
  output logic                                   data_gnt_o,
  input  logic                                   data_we_i,
  input  logic [3:0]                             data_be_i,
  input  logic [31:0]                            data_addr_i,
  input  logic [31:0]                            data_wdata_i,
  input  logic [RESP_INTG_W-1:0]                 data_wdata_intg_i,
  input  logic                                   stall_i,
  output logic                                   data_rvalid_o,
  output logic [31:0]                            data_rdata_o,
  output logic [RESP_INTG_W-1:0]                 data_rdata_intg_o,
  output logic                                   data_err_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned IdxW = $clog2(MemWords);
  localparam logic [32:0] Span = 33'(MemWords) * 33'd4;

  logic [31:0]     mem [MemWords];
  logic [IdxW-1:0] idx;
  logic [CntW:0]   live;
  logic            accept;
  logic            intg_err;
  logic            req_err;
  resp_entry_t     push;
  resp_entry_t     head;

  // A response retiring this cycle frees its slot for an immediate new grant.
  assign live       = {1'b0, outstanding_o} - {{CntW{1'b0}}, data_rvalid_o};
  assign data_gnt_o = data_req_i & ~stall_i & ~rst_i & (live < (CntW+1)'(MaxOutstanding));
  assign accept     = data_gnt_o;
  assign idx        = data_addr_i[IdxW+1:2];

`ifdef IBEX_RESP_INTG_CHECK_EN
  logic [38:0] wdata_enc;
  logic        unused_wenc;

  prim_secded_inv_39_32_enc u_wdata_enc (
    .data_i (data_wdata_i),
    .data_o (wdata_enc)
  );

  assign intg_err    = data_we_i & (wdata_enc[38:32] != data_wdata_intg_i);
  assign unused_wenc = ^wdata_enc[31:0];
`else
  logic unused_intg;

  assign intg_err    = 1'b0;
  assign unused_intg = ^data_wdata_intg_i;
`endif

  assign req_err = ~addr_in_range(data_addr_i, BaseAddr, Span)
                 | (data_addr_i[1:0] != 2'b00)
                 | intg_err;

  always_comb begin
    push       = '0;
    push.valid = accept;
    push.err   = accept & req_err;
    if (accept && !data_we_i && !req_err) push.rdata = mem[idx];
  end

  // Writes commit at the grant edge so a read granted next cycle sees them.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_o <= '0;
    end else if (accept && !data_rvalid_o) begin
      outstanding_o <= outstanding_o + 1'b1;
    end else if (!accept && data_rvalid_o) begin
      outstanding_o <= outstanding_o - 1'b1;
    end
  end

  ibex_mem_resp_pipe #(
    .Depth (ResponseLatency)
  ) u_pipe (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push),
    .head (head)
  );

  assign data_rvalid_o = head.valid;
  assign data_err_o    = head.valid & head.err;
  assign data_rdata_o  = head.rdata;

  logic [38:0] rdata_enc;
  logic        unused_renc;

  prim_secded_inv_39_32_enc u_rdata_enc (
    .data_i (data_rdata_o),
    .data_o (rdata_enc)
  );

  assign data_rdata_intg_o = rdata_enc[38:32];
  assign unused_renc       = ^rdata_enc[31:0];

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Directed plus random checks of ibex_data_mem_responder against a queue-based model.
module tb_ibex_data_mem_responder;

  localparam int unsigned WORDS = 1024;
  localparam int unsigned LAT   = 3;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [6:0]  wintg = '0;
  logic        stall = 1'b0;
  logic        rvalid;
  logic [31:0] rdata;
  logic [6:0]  rintg;
  logic        err;
  logic [1:0]  outstanding;

  always #5 clk = ~clk;

  ibex_data_mem_responder #(
    .MemWords        (WORDS),
    .BaseAddr        (32'h0000_0000),
    .ResponseLatency (LAT),
    .MaxOutstanding  (MAXO)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .data_req_i        (req),
    .data_gnt_o        (gnt),
    .data_we_i         (we),
    .data_be_i         (be),
    .data_addr_i       (addr),
    .data_wdata_i      (wdata),
    .data_wdata_intg_i (wintg),
    .stall_i           (stall),
    .data_rvalid_o     (rvalid),
    .data_rdata_o      (rdata),
    .data_rdata_intg_o (rintg),
    .data_err_o        (err),
    .outstanding_o     (outstanding)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [WORDS];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        dut_gnt_seen;

  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  e;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int i = 0; i < 7; i++) e[i] = ^(d & m[i]);
    return e ^ 7'h2A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic        e_rv, e_err, e_gnt, bad;
    logic [31:0] e_rd;
    int          live;
    exp_t        ent;
    @(negedge clk);
    e_rv  = (q.size() > 0) && (q[0].due == cyc);
    e_rd  = e_rv ? q[0].rdata : 32'h0;
    e_err = e_rv ? q[0].err : 1'b0;
    live  = q.size() - (e_rv ? 1 : 0);
    e_gnt = req && !stall && !rst && (live < MAXO);
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("rvalid", 64'(rvalid), 64'(e_rv));
    chk("rdata", 64'(rdata), 64'(e_rd));
    chk("rdata_intg", 64'(rintg), 64'(enc(e_rd)));
    chk("err", 64'(err), 64'(e_err));
    chk("outstanding", 64'(outstanding), 64'(q.size()));
    dut_gnt_seen = gnt;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (e_rv) void'(q.pop_front());
      if (e_gnt) begin
        bad = (addr >= 32'(WORDS * 4)) || (addr[1:0] != 2'b00);
`ifdef IBEX_RESP_INTG_CHECK_EN
        if (we && wintg != enc(wdata)) bad = 1'b1;
`endif
        ent.due   = cyc + LAT;
        ent.err   = bad;
        ent.rdata = (!bad && !we) ? mm[addr[11:2]] : 32'h0;
        if (!bad && we)
          for (int b = 0; b < 4; b++)
            if (be[b]) mm[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
        q.push_back(ent);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Hold a request until the DUT grants it, bounded.
  task automatic xfer(input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [6:0] flip);
    logic done;
    done = 1'b0;
    req = 1'b1; we = w; be = b; addr = a; wdata = d; wintg = enc(d) ^ flip;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = dut_gnt_seen;
    end
    chk("xfer_granted", 64'(done), 64'(1'b1));
    req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mm[i] = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;

    // Seed the words random traffic may read.
    for (int i = 0; i < 16; i++) xfer(1'b1, 4'hF, 32'(i * 4), $urandom, 7'h0);
    idle(LAT + 1);

    xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 7'h0);
    xfer(1'b0, 4'hF, 32'h10, 32'h0, 7'h0);
    idle(LAT + 1);
    xfer(1'b1, 4'b0010, 32'h10, 32'h0000AB00, 7'h0);
    xfer(1'b0, 4'hF, 32'h10, 32'h0, 7'h0);
    idle(LAT + 1);
    xfer(1'b0, 4'hF, 32'h1000, 32'h0, 7'h0);
    xfer(1'b0, 4'hF, 32'h12, 32'h0, 7'h0);
    xfer(1'b1, 4'hF, 32'h1000, 32'h12345678, 7'h0);
    xfer(1'b1, 4'h0, 32'h14, 32'hFFFFFFFF, 7'h0);
    xfer(1'b0, 4'hF, 32'h14, 32'h0, 7'h0);
    idle(LAT + 1);

    // Back-to-back reads hit the outstanding limit.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10; wdata = '0; wintg = enc(32'h0);
    for (int i = 0; i < 6; i++) cycle();
    idle(LAT + 1);

    // Stall blocks grants regardless of req.
    stall = 1'b1; req = 1'b1; addr = 32'h8;
    for (int i = 0; i < 4; i++) cycle();
    stall = 1'b0;
    cycle();
    idle(LAT + 1);

    // Reset the cycle after a read grant drops the response.
    xfer(1'b0, 4'hF, 32'h10, 32'h0, 7'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(LAT + 2);

`ifdef IBEX_RESP_INTG_CHECK_EN
    xfer(1'b1, 4'hF, 32'h20, 32'h1, 7'h01);
    xfer(1'b0, 4'hF, 32'h20, 32'h0, 7'h0);
    idle(LAT + 1);
`endif

    for (int i = 0; i < 400; i++) begin
      int sel;
      req   = ($urandom_range(3) != 0);
      we    = $urandom_range(1);
      be    = 4'($urandom);
      wdata = $urandom;
      stall = ($urandom_range(7) == 0);
      rst   = ($urandom_range(63) == 0);
      sel   = $urandom_range(15);
      if (sel < 12)       addr = 32'($urandom_range(15) * 4);
      else if (sel == 12) addr = 32'($urandom_range(15) * 4 + $urandom_range(1, 3));
      else                addr = $urandom | 32'h0000_1000;
      wintg = enc(wdata);
`ifdef IBEX_RESP_INTG_CHECK_EN
      if ($urandom_range(7) == 0) wintg = wintg ^ 7'(1 << $urandom_range(6));
`endif
      cycle();
    end
    rst = 1'b0; stall = 1'b0;
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
